execute_stage: RTL
==================

# execute_stage

Parametrised, pipelined Y86-64 execute stage: computes `valE`, owns the architectural condition-code register and resolves `cnd` for `jXX`/`cmovXX`. Sits between decode and memory, with valid/ready handshakes on both sides and a registered E→M output. An optional iterative multiplier adds a multi-cycle `mulq`.

## Interface
- `WIDTH`, 64: data width of `valA`/`valB`/`valC`/`valE`; must be ≥ 8.
- `STACK_STEP`, 8: stack pointer increment/decrement for push/pop/call/ret.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `icode`, `ifun`  in  4 each  instruction code and function.
- `valA`, `valB`, `valC`  in  WIDTH  operands.
- `set_cc_en`  in  1  permits CC update; sampled at accept.
- `out_valid`  out  1  E→M register holds a result.
- `out_ready`  in  1  memory stage consumes the result.
- `out_icode`, `out_ifun`  out  4 each  passed through.
- `out_valA`  out  WIDTH  passed through.
- `out_valE`  out  WIDTH  ALU result.
- `out_cnd`  out  1  condition outcome.
- `out_err`  out  1  invalid icode/ifun.
- `cc_o`  out  3  CC register: [0]=ZF, [1]=SF, [2]=OF.

## Operation
- Accept = `in_valid & in_ready`. `in_ready = (state==IDLE) & (~out_valid | out_ready)`.
- `valE` by `icode`:
  - 6 OPq, ifun 0/1/2/3: `valB+valA`, `valB-valA`, `valB&valA`, `valB^valA`.
  - 4/5 rmmovq/mrmovq: `valB+valC`.
  - 3 irmovq: `valC`.
  - 2 rrmovq/cmovXX: `valA`.
  - 10/8 pushq/call: `valB-STEP`.
  - 11/9 popq/ret: `valB+STEP`.
  - 0/1/7: 0.
- All arithmetic is modulo 2^WIDTH.
- CC update: only on accepted OPq with `set_cc_en=1` and no error.
  - ZF = (result==0); SF = result[WIDTH-1].
  - OF for add: sign(valB)==sign(valA) && sign(t)!=sign(valB).
  - OF for sub: sign(valB)!=sign(valA) && sign(t)!=sign(valB).
  - OF for and/xor: 0.
- Condition, for `icode` 2 and 7, using CC value *before* the accepting edge:
  - ifun 0: 1; 1 le: (SF^OF)|ZF; 2 l: SF^OF; 3 e: ZF; 4 ne: ~ZF; 5 ge: ~(SF^OF); 6 g: ~(SF^OF)&~ZF.
  - `out_cnd=0` for all other icodes.
- Errors:
  - Error conditions: icode > 11, OPq ifun outside the supported set, or cond ifun > 6.
  - Response: `out_err=1`, `out_valE=0`, `out_cnd=0`, no CC update.
  - The instruction still flows through with `out_valid=1`.
- FSM: IDLE, MUL (see Configuration). Single-cycle ops never leave IDLE.

## Timing
- Reset values:
  - `out_valid=0`.
  - `out_valE`, `out_valA`, `out_icode`, `out_ifun`, `out_cnd`, `out_err` = 0.
  - `cc_o=3'b001`.
  - state = IDLE, so `in_ready=1`.
- Single-cycle latency: accept at edge N → `out_*` valid after edge N; CC updates at edge N.
- Output register holds stable while `out_valid & ~out_ready`. In that state `in_ready=0` and the upstream instruction is neither accepted nor allowed to update CC.
- Simultaneous `out_ready` and accept: the old result leaves and the new one loads on the same edge, giving back-to-back throughput of 1/cycle.
- Reset asserted at any time, including mid-multiply: immediate return to reset values, multiply discarded.

## Configuration
- `EXEC_MUL_EN` defined:
  - OPq ifun 4 = `mulq`: unsigned `valB*valA`, low WIDTH bits to `valE`.
  - Iterative shift-add, one bit per cycle.
  - Accept → MUL for WIDTH cycles (`in_ready=0`) → result loads into output register → IDLE. Latency WIDTH+1 edges.
  - CC written at load when `set_cc_en` was 1 at accept: ZF/SF from the low word; OF=1 if any high-half product bit ≠ 0.
  - Output loading waits in MUL while the output register is occupied.
- `EXEC_MUL_EN` not defined: OPq ifun 4 is an error; no MUL state.

## Test plan
- addq `valB=0x7FFF_FFFF_FFFF_FFFF`, `valA=1` → `valE=0x8000_0000_0000_0000`, `cc_o=3'b110`. Then jl → `cnd=0`; jle → `cnd=0`.
- subq 5−5 → `valE=0`, `cc_o=3'b001`. Then cmove with `valA=0x1234` → `valE=0x1234`, `cnd=1`. Then jne → `cnd=0`.
- Back-pressure:
  - Stimulus: hold `out_ready=0` for 3 cycles with a result pending and an xorq waiting.
  - Required: `in_ready=0`, `out_*` stable, `cc_o` unchanged until the xorq is accepted.
- pushq `valB=0x100` → `valE=0xF8`; popq → `0x108`. subq 1−2 with `set_cc_en=0` → `cc_o` unchanged. icode 12 → `out_err=1`.
- `EXEC_MUL_EN`:
  - 3×7 → `valE=21` 65 edges after accept, with `in_ready=0` for 64 cycles.
  - 2^32×2^32 → `valE=0`, `cc_o=3'b101`.
  - Without the macro: ifun 4 → `out_err=1`, CC unchanged.
- `rst_n` low at cycle 10 of a mulq → `out_valid=0`, `cc_o=3'b001`, `in_ready=1` immediately; next add after release is correct.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : execute_stage                                           |
// | Purpose  : Y86-64 execute stage. Computes valE, owns the condition |
// |            code register, resolves cnd for jXX/cmovXX and holds    |
// |            the result in a registered E->M stage with valid/ready  |
// |            handshakes on both sides.                               |
// | Options  : EXEC_MUL_EN enables OPq ifun 4 (mulq) as an iterative   |
// |            shift-add multiply, one multiplier bit per cycle.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module execute_stage #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic             set_cc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [3:0]       out_ifun,
    output logic [WIDTH-1:0] out_valA,
    output logic [WIDTH-1:0] out_valE,
    output logic             out_cnd,
    output logic             out_err,
    output logic [2:0]       cc_o
);

    localparam logic [3:0] c_I_RRMOVQ = 4'd2;
    localparam logic [3:0] c_I_IRMOVQ = 4'd3;
    localparam logic [3:0] c_I_RMMOVQ = 4'd4;
    localparam logic [3:0] c_I_MRMOVQ = 4'd5;
    localparam logic [3:0] c_I_OPQ    = 4'd6;
    localparam logic [3:0] c_I_JXX    = 4'd7;
    localparam logic [3:0] c_I_CALL   = 4'd8;
    localparam logic [3:0] c_I_RET    = 4'd9;
    localparam logic [3:0] c_I_PUSHQ  = 4'd10;
    localparam logic [3:0] c_I_POPQ   = 4'd11;
    localparam logic [3:0] c_F_MULQ   = 4'd4;
    localparam logic [3:0] c_F_CONDMAX = 4'd6;
`ifdef EXEC_MUL_EN
    localparam logic [3:0] c_F_OPQMAX = 4'd4;
`else
    localparam logic [3:0] c_F_OPQMAX = 4'd3;
`endif
    localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STACK_STEP);

    // CC register: [0]=ZF, [1]=SF, [2]=OF
    logic [2:0]       r_cc;

    logic             w_is_opq;
    logic             w_is_cond;
    logic             w_err;
    logic             w_out_free;
    logic             w_accept;
    logic             w_idle;
    logic             w_is_mul;
    logic             w_load_single;
    logic             w_mul_load;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_of;
    logic [WIDTH-1:0] w_vale;
    logic             w_cond_true;
    logic             w_cnd;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_mul_vala;
    logic             w_mul_hi_nz;
    logic             w_mul_setcc;

    assign w_is_opq  = (icode == c_I_OPQ);
    assign w_is_cond = (icode == c_I_RRMOVQ) | (icode == c_I_JXX);
    assign w_err     = (icode > c_I_POPQ)
                     | (w_is_opq  & (ifun > c_F_OPQMAX))
                     | (w_is_cond & (ifun > c_F_CONDMAX));

    // The output slot is free if empty or being drained on this edge
    assign w_out_free    = ~out_valid | out_ready;
    assign in_ready      = w_idle & w_out_free;
    assign w_accept      = in_valid & in_ready;
    assign w_load_single = w_accept & ~w_is_mul;
    assign cc_o          = r_cc;

    // OPq ALU result and signed-overflow flag
    always_comb begin
        w_alu_res = '0;
        w_alu_of  = 1'b0;
        case (ifun)
            4'd0: begin
                w_alu_res = valB + valA;
                w_alu_of  = (valB[WIDTH-1] == valA[WIDTH-1]) &
                            (w_alu_res[WIDTH-1] != valB[WIDTH-1]);
            end
            4'd1: begin
                w_alu_res = valB - valA;
                w_alu_of  = (valB[WIDTH-1] != valA[WIDTH-1]) &
                            (w_alu_res[WIDTH-1] != valB[WIDTH-1]);
            end
            4'd2:    w_alu_res = valB & valA;
            4'd3:    w_alu_res = valB ^ valA;
            default: ;
        endcase
    end

    // valE selection by instruction class; errors force zero
    always_comb begin
        w_vale = '0;
        case (icode)
            c_I_OPQ:                w_vale = w_alu_res;
            c_I_RMMOVQ, c_I_MRMOVQ: w_vale = valB + valC;
            c_I_IRMOVQ:             w_vale = valC;
            c_I_RRMOVQ:             w_vale = valA;
            c_I_PUSHQ, c_I_CALL:    w_vale = valB - c_STEP;
            c_I_POPQ, c_I_RET:      w_vale = valB + c_STEP;
            default:                ;
        endcase
        if (w_err) begin
            w_vale = '0;
        end
    end

    // Branch / cmov condition from the CC value before this edge
    always_comb begin
        w_cond_true = 1'b0;
        case (ifun)
            4'd0:    w_cond_true = 1'b1;
            4'd1:    w_cond_true = (r_cc[1] ^ r_cc[2]) | r_cc[0];
            4'd2:    w_cond_true = r_cc[1] ^ r_cc[2];
            4'd3:    w_cond_true = r_cc[0];
            4'd4:    w_cond_true = ~r_cc[0];
            4'd5:    w_cond_true = ~(r_cc[1] ^ r_cc[2]);
            4'd6:    w_cond_true = ~(r_cc[1] ^ r_cc[2]) & ~r_cc[0];
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_cnd = w_is_cond & ~w_err & w_cond_true;

`ifdef EXEC_MUL_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int                c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mul_vala;
    logic [c_CW-1:0]  r_cnt;
    logic             r_mul_setcc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_hi_step;
    logic [WIDTH-1:0] w_lo_step;
    logic             w_last;

    // One shift-add step: r_lo starts as the multiplier and fills with
    // product low bits as multiplier bits are consumed from the bottom.
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_hi_step = w_sum[WIDTH:1];
    assign w_lo_step = {w_sum[0], r_lo[WIDTH-1:1]};
    assign w_last    = (r_cnt == c_LAST);

    assign w_is_mul    = w_is_opq & (ifun == c_F_MULQ);
    assign w_idle      = (r_state == IDLE);
    // The final step is applied combinationally as the result loads,
    // so it may stall there until the output slot frees up.
    assign w_mul_load  = (r_state == MUL) & w_last & w_out_free;
    assign w_mul_lo    = w_lo_step;
    assign w_mul_hi_nz = |w_hi_step;
    assign w_mul_vala  = r_mul_vala;
    assign w_mul_setcc = r_mul_setcc;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: enter MUL on an accepted mulq, leave on result load
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept & w_is_mul) w_state_nxt = MUL;
            MUL:     if (w_mul_load)          w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Multiplier datapath: capture operands at accept, then iterate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_mcand     <= '0;
            r_mul_vala  <= '0;
            r_cnt       <= '0;
            r_mul_setcc <= 1'b0;
        end else if (w_accept & w_is_mul) begin
            r_hi        <= '0;
            r_lo        <= valA;
            r_mcand     <= valB;
            r_mul_vala  <= valA;
            r_cnt       <= '0;
            r_mul_setcc <= set_cc_en;
        end else if ((r_state == MUL) & ~w_last) begin
            r_hi  <= w_hi_step;
            r_lo  <= w_lo_step;
            r_cnt <= r_cnt + c_CW'(1);
        end
    end
`else
    assign w_is_mul    = 1'b0;
    assign w_idle      = 1'b1;
    assign w_mul_load  = 1'b0;
    assign w_mul_lo    = '0;
    assign w_mul_hi_nz = 1'b0;
    assign w_mul_vala  = '0;
    assign w_mul_setcc = 1'b0;
`endif

    // E->M register: load a finished instruction, or drain when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_icode <= '0;
            out_ifun  <= '0;
            out_valA  <= '0;
            out_valE  <= '0;
            out_cnd   <= 1'b0;
            out_err   <= 1'b0;
        end else if (w_load_single) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            out_ifun  <= ifun;
            out_valA  <= valA;
            out_valE  <= w_vale;
            out_cnd   <= w_cnd;
            out_err   <= w_err;
        end else if (w_mul_load) begin
            out_valid <= 1'b1;
            out_icode <= c_I_OPQ;
            out_ifun  <= c_F_MULQ;
            out_valA  <= w_mul_vala;
            out_valE  <= w_mul_lo;
            out_cnd   <= 1'b0;
            out_err   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Condition codes: written by accepted error-free OPq or a mulq load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 3'b001;
        end else if (w_load_single & w_is_opq & set_cc_en & ~w_err) begin
            r_cc <= {w_alu_of, w_alu_res[WIDTH-1], (w_alu_res == '0)};
        end else if (w_mul_load & w_mul_setcc) begin
            r_cc <= {w_mul_hi_nz, w_mul_lo[WIDTH-1], (w_mul_lo == '0)};
        end
    end

endmodule
`default_nettype wire
